// File: rtl/booth4_pp_gen_pipe_if.sv
// rtl/booth4_pp_gen_pipe_if.sv - operand-in / partial-product-out handshake bundle
interface booth4_pp_gen_pipe_if #(
   parameter int DW = 16
);
   logic                  flush;
   logic                  in_valid;
   logic                  in_ready;
   logic [DW-1:0]         mul_a;
   logic [DW-1:0]         mul_b;
   logic                  pp_valid;
   logic                  pp_ready;
   logic [DW+3:0]         pp0;
   logic [7*(DW+2)-1:0]   pp_rows;
   logic [DW/2-1:0]       neg;

   modport master (
      output flush, in_valid, mul_a, mul_b, pp_ready,
      input  in_ready, pp_valid, pp0, pp_rows, neg
   );

   modport slave (
      input  flush, in_valid, mul_a, mul_b, pp_ready,
      output in_ready, pp_valid, pp0, pp_rows, neg
   );
endinterface

// File: rtl/booth4_pp_gen_pipe.sv
// rtl/booth4_pp_gen_pipe.sv - radix-4 Booth partial-product generator, elastic two-stage pipe
module booth4_pp_gen_pipe #(
   parameter int DW     = 16,
   parameter bit IN_REG = 1'b1
) (
   input  logic                sys_clk,
   input  logic                sys_rst_n,
   booth4_pp_gen_pipe_if.slave bus
);
   localparam int ND = DW / 2;
   localparam int RW = DW + 1;
   localparam int PW = DW + 2;

   logic [DW-1:0]        src_a;
   logic [DW-1:0]        src_b;
   logic                 src_v;
   logic                 s2_free;
   logic                 s2_load;

   logic                 v2_q;
   logic                 v2_d;
   logic [DW+3:0]        pp0_q;
   logic [(ND-1)*PW-1:0] rows_q;
   logic [ND-1:0]        neg_q;

   logic [DW:0]          b_ext;
   logic [RW-1:0]        a_x1;
   logic [RW-1:0]        a_x2;
   logic [RW-1:0]        mag;
   logic [2:0]           trip;
   logic [RW-1:0]        raw [ND];
   logic [ND-1:0]        rec_neg;
   logic [DW+3:0]        rec_pp0;
   logic [(ND-1)*PW-1:0] rec_rows;

   assign s2_free = !v2_q || bus.pp_ready;
   assign s2_load = src_v && s2_free && !bus.flush;

   generate
      if (IN_REG) begin : g_s1
         logic          v1_q;
         logic          v1_d;
         logic          s1_load;
         logic [DW-1:0] a1_q;
         logic [DW-1:0] b1_q;

         // No skid buffer: readiness looks straight through to the tree's pp_ready.
         assign bus.in_ready = !bus.flush && (!v1_q || s2_free);
         assign s1_load      = bus.in_valid && bus.in_ready;

         always_comb begin
            v1_d = v1_q;
            if (bus.flush)    v1_d = 1'b0;
            else if (s1_load) v1_d = 1'b1;
            else if (s2_load) v1_d = 1'b0;
         end

         always_ff @(posedge sys_clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
               v1_q <= 1'b0;
               a1_q <= '0;
               b1_q <= '0;
            end else begin
               v1_q <= v1_d;
               if (s1_load) begin
                  a1_q <= bus.mul_a;
                  b1_q <= bus.mul_b;
               end
            end
         end

         assign src_a = a1_q;
         assign src_b = b1_q;
         assign src_v = v1_q;
      end else begin : g_bypass
         assign bus.in_ready = !bus.flush && s2_free;
         assign src_a        = bus.mul_a;
         assign src_b        = bus.mul_b;
         assign src_v        = bus.in_valid;
      end
   endgenerate

   // b_ext[0] is the implicit b[-1] = 0, so digit i reads b_ext[2i+2:2i].
   always_comb begin
      b_ext   = {src_b, 1'b0};
      a_x1    = {src_a[DW-1], src_a};
      a_x2    = {src_a, 1'b0};
      rec_neg = '0;
      mag     = '0;
      trip    = '0;
      for (int i = 0; i < ND; i++) begin
         trip = b_ext[2*i +: 3];
         case (trip)
            3'b001, 3'b010, 3'b101, 3'b110: mag = a_x1;
            3'b011, 3'b100:                 mag = a_x2;
            default:                        mag = '0;
         endcase
         rec_neg[i] = trip[2] & ~(trip[1] & trip[0]);
         raw[i]     = rec_neg[i] ? ~mag : mag;
      end
   end

   always_comb begin
      rec_pp0  = {~raw[0][RW-1], raw[0][RW-1], raw[0][RW-1], raw[0]};
      rec_rows = '0;
      for (int i = 1; i < ND; i++) begin
         rec_rows[(i-1)*PW +: PW] = {~raw[i][RW-1], raw[i]};
      end
   end

   always_comb begin
      v2_d = v2_q;
      if (bus.flush)         v2_d = 1'b0;
      else if (s2_load)      v2_d = 1'b1;
      else if (bus.pp_ready) v2_d = 1'b0;
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         v2_q   <= 1'b0;
         pp0_q  <= '0;
         rows_q <= '0;
         neg_q  <= '0;
      end else begin
         v2_q <= v2_d;
         if (s2_load) begin
            pp0_q  <= rec_pp0;
            rows_q <= rec_rows;
            neg_q  <= rec_neg;
         end
      end
   end

   assign bus.pp_valid = v2_q;
   assign bus.pp0      = pp0_q;
   assign bus.pp_rows  = rows_q;
   assign bus.neg      = neg_q;
endmodule
